// File: rtl/p2s_tx_if.sv
// Serial transmit link bundle: parallel word handshake plus serial-side outputs.
// Handshake rule: a word moves on a rising clk edge where p2s_valid and
// p2s_ready are both high. The producer must hold p2s_din and p2s_valid
// stable until that edge. p2s_ready never depends on p2s_valid in the same
// cycle.
interface p2s_tx_if #(
  parameter int DW = 22
);
  logic [DW-1:0] p2s_din;
  logic          p2s_valid;
  logic          p2s_ready;
  logic          p2s_dout;
  logic          p2s_start;
  logic          p2s_busy;
  logic          p2s_done;

  modport master (
    output p2s_din, p2s_valid,
    input  p2s_ready, p2s_dout, p2s_start, p2s_busy, p2s_done
  );

  modport slave (
    input  p2s_din, p2s_valid,
    output p2s_ready, p2s_dout, p2s_start, p2s_busy, p2s_done
  );
endinterface

// File: rtl/p2s_tx.sv
// p2s_tx: parallel-to-serial transmitter. Takes a DW-bit word on a
// valid/ready handshake, emits a one-cycle start strobe, shifts the word out
// MSB first, then pulses done and holds off the producer for GAP cycles.
// Optional build macro P2S_PARITY_EN appends an even-parity bit after the LSB.
// All outputs are registered; state_o exposes the FSM state for debug.
module p2s_tx #(
  parameter int DW  = 22,
  parameter int AW  = 5,
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  p2s_tx_if.slave    bus,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [AW-1:0] CNT_LAST = AW'(DW - 1);
  localparam logic [AW-1:0] GAP_L    = AW'(GAP);

  state_t        state_q;
  logic [DW-1:0] sr_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] gcnt_q;
  logic          ready_q;
  logic          dout_q;
  logic          start_q;
  logic          busy_q;
  logic          done_q;
`ifdef P2S_PARITY_EN
  logic          par_q;
  logic          par_ph_q;
`endif

  // Frame sequencer: every output is computed here for the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      ready_q  <= 1'b1;
      dout_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef P2S_PARITY_EN
      par_q    <= 1'b0;
      par_ph_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.p2s_valid && ready_q) begin
            sr_q    <= bus.p2s_din;
`ifdef P2S_PARITY_EN
            par_q   <= ^bus.p2s_din;
`endif
            ready_q <= 1'b0;
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          // First data bit goes out next cycle; the word shifts left so the
          // next bit to send is always at the top.
          start_q <= 1'b0;
          busy_q  <= 1'b1;
          dout_q  <= sr_q[DW-1];
          sr_q    <= {sr_q[DW-2:0], 1'b0};
          cnt_q   <= '0;
`ifdef P2S_PARITY_EN
          par_ph_q <= 1'b0;
`endif
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q  <= cnt_q + AW'(1);
            dout_q <= sr_q[DW-1];
            sr_q   <= {sr_q[DW-2:0], 1'b0};
          end
`ifdef P2S_PARITY_EN
          else if (!par_ph_q) begin
            // LSB is on the line now; parity follows as one more busy beat.
            par_ph_q <= 1'b1;
            dout_q   <= par_q;
          end
`endif
          else begin
            busy_q <= 1'b0;
            dout_q <= 1'b0;
            done_q <= 1'b1;
            if (GAP > 0) begin
              gcnt_q  <= GAP_L;
              state_q <= S_GAP;
            end else begin
              // No gap: ready rises alongside done for back-to-back frames.
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          done_q <= 1'b0;
          if (gcnt_q <= AW'(1)) begin
            gcnt_q  <= '0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q - AW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          start_q <= 1'b0;
          done_q  <= 1'b0;
          dout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p2s_ready = ready_q;
  assign bus.p2s_dout  = dout_q;
  assign bus.p2s_start = start_q;
  assign bus.p2s_busy  = busy_q;
  assign bus.p2s_done  = done_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_p2s_tx.sv
// Directed bench for p2s_tx: one instance with GAP=1 and one with GAP=0,
// selected through a shared stimulus/observation mux.
module tb_p2s_tx;
  localparam int DW = 22;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          sel;     // 0: GAP=1 instance, 1: GAP=0 instance
  logic          valid;
  logic [DW-1:0] din;
  logic [1:0]    state1;
  logic [1:0]    state0;

  int compared;
  int mismatched;

  p2s_tx_if #(.DW(DW)) bus1 ();
  p2s_tx_if #(.DW(DW)) bus0 ();

  assign bus1.p2s_din   = din;
  assign bus0.p2s_din   = din;
  assign bus1.p2s_valid = valid & ~sel;
  assign bus0.p2s_valid = valid & sel;

  p2s_tx #(.DW(DW), .AW(AW), .GAP(1)) u_g1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_o(state1)
  );

  p2s_tx #(.DW(DW), .AW(AW), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_o(state0)
  );

  wire       m_ready = sel ? bus0.p2s_ready : bus1.p2s_ready;
  wire       m_dout  = sel ? bus0.p2s_dout  : bus1.p2s_dout;
  wire       m_start = sel ? bus0.p2s_start : bus1.p2s_start;
  wire       m_busy  = sel ? bus0.p2s_busy  : bus1.p2s_busy;
  wire       m_done  = sel ? bus0.p2s_done  : bus1.p2s_done;
  wire [1:0] m_state = sel ? state0 : state1;

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for ready, then present one word for exactly one edge.
  // Returns 1 time unit into cycle T+1.
  task automatic hs(input logic [DW-1:0] w);
    int k;
    k = 0;
    while (m_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_wait", {31'd0, m_ready}, 32'd1);
    din   = w;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Check a whole frame starting in cycle T+1.
  task automatic body(input logic [DW-1:0] w, input bit chg, input bit pulse,
                      input bit hold, input logic [DW-1:0] nxt);
    chk("st_start", {31'd0, m_start}, 32'd1);
    chk("st_busy",  {31'd0, m_busy},  32'd0);
    chk("st_dout",  {31'd0, m_dout},  32'd0);
    chk("st_done",  {31'd0, m_done},  32'd0);
    chk("st_ready", {31'd0, m_ready}, 32'd0);
    chk("st_state", {30'd0, m_state}, 32'd1);
    for (int i = 0; i < DW; i++) begin
      @(posedge clk); #1;
      if (pulse && i == 6) valid = 1'b0;
      chk("bit_busy",  {31'd0, m_busy},  32'd1);
      chk("bit_dout",  {31'd0, m_dout},  {31'd0, w[DW-1-i]});
      chk("bit_start", {31'd0, m_start}, 32'd0);
      chk("bit_done",  {31'd0, m_done},  32'd0);
      chk("bit_ready", {31'd0, m_ready}, 32'd0);
      if (chg && i == 3) din = 22'h3FFFFF;
      if (pulse && i == 5) begin
        valid = 1'b1;
        din   = 22'h155555;
      end
    end
`ifdef P2S_PARITY_EN
    @(posedge clk); #1;
    chk("par_busy", {31'd0, m_busy}, 32'd1);
    chk("par_dout", {31'd0, m_dout}, {31'd0, ^w});
    chk("par_done", {31'd0, m_done}, 32'd0);
`endif
    @(posedge clk); #1;
    chk("dn_done",  {31'd0, m_done},  32'd1);
    chk("dn_busy",  {31'd0, m_busy},  32'd0);
    chk("dn_dout",  {31'd0, m_dout},  32'd0);
    chk("dn_start", {31'd0, m_start}, 32'd0);
    chk("dn_ready", {31'd0, m_ready}, {31'd0, sel});
    if (pulse) begin
      valid = 1'b1;
      din   = 22'h2DB6DB;
    end
    if (hold) begin
      valid = 1'b1;
      din   = nxt;
      @(posedge clk); #1;
      valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      chk("post_done",  {31'd0, m_done},  32'd0);
      chk("post_ready", {31'd0, m_ready}, 32'd1);
      chk("post_start", {31'd0, m_start}, 32'd0);
      if (pulse) begin
        valid = 1'b0;
        @(posedge clk); #1;
        chk("pulse_start", {31'd0, m_start}, 32'd0);
        chk("pulse_state", {30'd0, m_state}, 32'd0);
        chk("pulse_ready", {31'd0, m_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    int dn;
    compared   = 0;
    mismatched = 0;
    sel   = 1'b0;
    valid = 1'b0;
    din   = '0;
    rst   = 1'b1;

    // Reset values on both instances
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, m_ready}, 32'd1);
    chk("rst_dout",  {31'd0, m_dout},  32'd0);
    chk("rst_start", {31'd0, m_start}, 32'd0);
    chk("rst_busy",  {31'd0, m_busy},  32'd0);
    chk("rst_done",  {31'd0, m_done},  32'd0);
    chk("rst_state", {30'd0, m_state}, 32'd0);
    sel = 1'b1;
    #1;
    chk("rst0_ready", {31'd0, m_ready}, 32'd1);
    chk("rst0_state", {30'd0, m_state}, 32'd0);
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Alternating pattern
    hs(22'h2AAAAA);
    body(22'h2AAAAA, 1'b0, 1'b0, 1'b0, '0);

    // MSB and LSB only; din changed mid-frame
    hs(22'h200001);
    body(22'h200001, 1'b1, 1'b0, 1'b0, '0);

    // valid pulsed during SHIFT and during the ready-low window
    hs(22'h0F0F0F);
    body(22'h0F0F0F, 1'b0, 1'b1, 1'b0, '0);

    // Reset mid-frame
    hs(22'h3C3C3C);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ab_ready", {31'd0, m_ready}, 32'd1);
    chk("ab_busy",  {31'd0, m_busy},  32'd0);
    chk("ab_dout",  {31'd0, m_dout},  32'd0);
    chk("ab_start", {31'd0, m_start}, 32'd0);
    chk("ab_done",  {31'd0, m_done},  32'd0);
    chk("ab_state", {30'd0, m_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (m_done === 1'b1) dn++;
    end
    chk("ab_no_done", dn, 32'd0);
    chk("ab_ready2", {31'd0, m_ready}, 32'd1);
    hs(22'h1234AB);
    body(22'h1234AB, 1'b0, 1'b0, 1'b0, '0);

    // Odd and even parity words
    hs(22'h000007);
    body(22'h000007, 1'b0, 1'b0, 1'b0, '0);
    hs(22'h000003);
    body(22'h000003, 1'b0, 1'b0, 1'b0, '0);

    // GAP=0 back-to-back with valid held through the done cycle
    sel = 1'b1;
    #1;
    hs(22'h000001);
    body(22'h000001, 1'b0, 1'b0, 1'b1, 22'h3FFFFF);
    body(22'h3FFFFF, 1'b0, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/p2s_tx.md
Name: p2s_tx

Overview:
Parallel-to-serial transmitter and the transmit end of the serial word link. It accepts a DW-bit word through a valid/ready handshake, emits a one-cycle frame strobe, then shifts the word out MSB-first, one bit per clk. It sits between the local producer (register/sequencer logic) and the serial line that feeds the remote deserializer.

Parameters:
DW, 22, data word width in bits; must be >= 2.
AW, 5, bit counter width; must satisfy 2^AW >= DW.
GAP, 1, idle cycles forced after each frame before the next word is accepted; range 0 to 2^AW-1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset; asynchronous, active-high.
p2s_din  input  DW  parallel word; sampled only on handshake.
p2s_valid  input  1  producer has a word on p2s_din.
p2s_ready  output  1  transmitter can accept a word (registered).
p2s_dout  output  1  serial data, MSB first.
p2s_start  output  1  one-cycle frame strobe, the cycle before the first data bit.
p2s_busy  output  1  high while data bits are on p2s_dout.
p2s_done  output  1  one-cycle pulse after the last bit of a frame.

Behaviour:
- Reset (async, any state): p2s_ready=1, p2s_dout=0, p2s_start=0, p2s_busy=0, p2s_done=0. Shift register=0, counters=0, state=IDLE. All outputs are registered.
- States: IDLE, START, SHIFT, GAP.
- IDLE:
  - p2s_ready=1.
  - Handshake at edge T (p2s_valid & p2s_ready): capture p2s_din into the shift register, p2s_ready<=0, go to START.
  - p2s_valid low: stay in IDLE.
- START (cycle T+1): p2s_start=1, p2s_dout=0, p2s_busy=0. Bit counter cleared. Go to SHIFT.
- SHIFT (cycles T+2 .. T+1+DW):
  - p2s_busy=1, p2s_start=0.
  - p2s_dout = word bit DW-1-cnt, so MSB first and LSB last. cnt increments each cycle.
  - At cnt==DW-1: go to GAP if GAP>0, else IDLE.
- Frame end (cycle T+2+DW):
  - p2s_done=1 for exactly one cycle; p2s_busy=0, p2s_dout=0.
  - If GAP==0: p2s_ready=1 in this same cycle, so a new handshake can occur at its end. Back-to-back frames then repeat every DW+2 cycles.
- GAP: ready held low for GAP cycles after the done cycle; p2s_ready=1 at cycle T+2+DW+GAP.
- Latency: handshake to first data bit is 2 cycles. Throughput is one word per DW+2+GAP cycles.
- p2s_valid while p2s_ready=0 is ignored; the producer must hold the word until ready. Changes to p2s_din after the handshake do not affect the frame in flight.
- p2s_dout=0 whenever p2s_busy=0.
- p2s_start, p2s_busy and p2s_done are mutually exclusive in every cycle.
- Reset mid-frame: the frame is aborted immediately and all outputs take their reset values. No p2s_done is emitted for the aborted word. The first frame after reset release starts from IDLE.
- Counter arithmetic: cnt is an unsigned AW-bit value that never exceeds DW-1 and does not wrap. The gap counter is also AW bits and counts down from GAP.

Optional Feature:
- Macro P2S_PARITY_EN.
- Defined:
  - One extra SHIFT cycle follows the LSB, with p2s_busy=1 and p2s_dout = even parity (XOR of all DW captured bits).
  - p2s_done, the GAP window and p2s_ready each move one cycle later.
  - Frame period becomes DW+3+GAP.
- Undefined: no parity cycle; timing exactly as in Behaviour.

Test Plan:
- Defaults (DW=22, GAP=1), handshake with p2s_din=22'h2AAAAA: p2s_start at T+1; p2s_dout=1,0,1,0,... for 22 cycles with p2s_busy=1; p2s_done at T+24; p2s_ready back at T+25.
- p2s_din=22'h200001: p2s_dout=1 at T+2, 0 for cycles T+3..T+22, 1 at T+23. p2s_din is changed to 22'h3FFFFF at T+5 and the output is unaffected.
- GAP=0 with p2s_valid held high and words 22'h000001 then 22'h3FFFFF: second handshake at the end of the done cycle; second p2s_start at T+DW+3; no idle bits beyond the start cycle.
- p2s_valid pulsed during SHIFT and GAP: no capture and no extra frame; the only handshake happens when p2s_ready=1.
- rst asserted at T+10 mid-frame: outputs take reset values within the same cycle (async), no p2s_done, p2s_ready=1 after release; the next word transmits correctly.
- P2S_PARITY_EN defined, p2s_din=22'h000007: parity bit 1 at T+24; p2s_done at T+25. With 22'h000003: parity bit 0.
